shift_op_sequencer: RTL and testbench
=====================================

// Module: shift_op_sequencer
// PURPOSE
//  Command-driven sequencer for one universal_shift_register instance (owned inside this block).
//  Accepts LOAD / shift / rotate commands over a valid/ready handshake.
//  Issues one register step per cycle for the requested count, then pulses done.
//  The register has no hold mode, so in every non-stepping cycle this block holds it by reloading o_q.
// PARAMETERS
//  WIDTH  4                     register width; must be >= 3.
//  CNT_W  $clog2(WIDTH)+1       step-count width; counts 0..WIDTH are legal.
// PORTS
//  i_clk        in   1      clock; all state changes on its rising edge.
//  i_rst        in   1      asynchronous, active-low reset.
//  i_cmd_valid  in   1      command present.
//  o_cmd_ready  out  1      command accepted when valid & ready at a rising edge.
//  i_cmd_op     in   3      0 LOAD, 1 SHL, 2 SHR, 3 ROTL, 4 ROTR; 5..7 illegal, treated as count-0 no-op.
//  i_cmd_count  in   CNT_W  number of steps (ignored for LOAD).
//  i_cmd_data   in   WIDTH  parallel data for LOAD.
//  i_serial_in  in   1      fill bit for SHL/SHR; sampled every step.
//  o_q          out  WIDTH  register contents.
//  o_serial_out out  1      bit leaving the register: q[WIDTH-1] for SHL/ROTL, else q[0].
//  o_busy       out  1      high in EXEC and DONE.
//  o_done       out  1      1-cycle pulse; o_q is final in that cycle.
// BEHAVIOUR
//  Reset: state IDLE, o_q=0, o_cmd_ready=1, o_busy=0, o_done=0, step counter=0.
//    Reset mid-command aborts it; no done pulse is issued.
//  States:
//    IDLE: ready=1; register held (en_load=1, load=o_q).
//      On handshake: capture op, count and data.
//      Go to EXEC; go straight to DONE if the op is not LOAD and count==0, or the op is illegal.
//    EXEC: ready=0; one register step per cycle; counter decrements.
//      LOAD: en_load=1, load=captured data, for exactly 1 cycle.
//      SHL:  {rot,sh}=00, load[0]=i_serial_in;        q <= {q[W-2:0], sin}.
//      SHR:  {rot,sh}=01, load[W-1]=i_serial_in;      q <= {sin, q[W-1:1]}.
//      ROTR: {rot,sh}=10;                             q <= {q[0], q[W-1:1]}.
//      ROTL: {rot,sh}=11;                             q <= {q[W-2:0], q[W-1]}.
//      Go to DONE after the last step's edge.
//    DONE: o_done=1, register held, ready=0; go to IDLE next cycle.
//  Latency, handshake at edge E0: LOAD done in cycle E1..E2; N-step op done in cycle after edge E(N);
//    count 0 done in cycle after E0. Throughput: one command per N+2 cycles (LOAD 3).
//  count==WIDTH: SHL/SHR fully replaces contents with fill bits; ROTL/ROTR returns the original value.
//  i_cmd_* may change freely while ready=0; they are captured only at the handshake.
//  No combinational path from i_cmd_valid to o_cmd_ready.
// CONFIGURATION
//  SHIFT_SEQ_ABORT_EN
//    Defined: adds input i_abort (1 bit).
//      i_abort=1 in an EXEC cycle: that cycle holds instead of stepping, state goes to DONE.
//      o_done pulses with o_aborted=1 (new 1-bit output, else 0); already-executed steps remain.
//      i_abort is ignored outside EXEC.
//    Undefined: neither port exists; commands always run to completion.
// STRUCTURE
//  Package shift_seq_pkg holds:
//    op encodings (OP_LOAD..OP_ROTR);
//    state encoding (ST_IDLE, ST_EXEC, ST_DONE);
//    {rotate,shift} mode constants (MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_ROTR=2'b10, MODE_ROTL=2'b11).
//  Sub-module: one universal_shift_register #(WIDTH) instance, i_rst passed directly.
//  Controller FSM, counter and d-mux logic stay in this module.
// TESTING (WIDTH=4)
//  1. Reset, then LOAD 4'b1011 -> o_done exactly 2 cycles after handshake, o_q=1011, ready back high next cycle.
//  2. From 1011: SHL count 2, sin=1 -> o_q 0111 then 1111; done 3 cycles after handshake.
//     Then SHR count 1, sin=0 -> 0111.
//  3. From 1011: ROTR 1 -> 1101; ROTL 4 -> 1101 unchanged after 4 steps; count 0 -> done next cycle, o_q unchanged.
//  4. Idle 20 cycles with no command, and toggling i_cmd_* with valid=0 -> o_q stays constant.
//  5. Reset asserted during step 2 of a ROTL 4 -> o_q=0 immediately, no done pulse,
//     ready=1 after reset release.
//  6. With SHIFT_SEQ_ABORT_EN: SHL 4 from 1011, sin=0, abort on 3rd EXEC cycle -> o_q=1100,
//     o_done=1 and o_aborted=1 next cycle.

Source files
------------

// File: rtl/shift_op_sequencer_pkg.sv
// Shared encodings for the shift-op sequencer: command ops, controller states
// and the {rotate,shift} step-mode codes of the universal shift register.
package shift_seq_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROTL = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SHL  = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROTR = 2'b10;
  localparam logic [1:0] MODE_ROTL = 2'b11;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ROTR);
  endfunction

  // Ops whose outgoing bit is the MSB; every other op shifts out of bit 0.
  function automatic logic op_exits_msb(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_ROTL);
  endfunction

endpackage

// File: rtl/shift_op_sequencer_usr.sv
// Universal shift register: parallel load or one shift/rotate step per cycle.
// There is no hold mode; the owner holds the value by reloading it.
module universal_shift_register
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en_load,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register value; fill bits for shifts come in on the matching load bit.
  always_comb begin
    q_d = q_q;
    if (i_en_load) begin
      q_d = i_load;
    end else begin
      case (i_mode)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], i_load[0]};
        MODE_SHR:  q_d = {i_load[WIDTH-1], q_q[WIDTH-1:1]};
        MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        default:   q_d = q_q;
      endcase
    end
  end

  // Register storage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/shift_op_sequencer.sv
// Command-driven sequencer around one universal_shift_register: LOAD/shift/rotate
// commands over valid/ready, one step per cycle, done pulse. Option: SHIFT_SEQ_ABORT_EN.
module shift_op_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic             i_serial_in,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             i_abort,
  output logic             o_aborted,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_serial_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             abort_s;
  logic             en_load_s;
  logic [1:0]       mode_s;
  logic [WIDTH-1:0] load_s;
  logic [WIDTH-1:0] q_s;
  logic             serial_out_s;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_s   = i_abort;
  assign o_aborted = aborted_q;
`else
  assign abort_s   = 1'b0;
`endif

  // Controller next-state, counter and command capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          op_d   = i_cmd_op;
          data_d = i_cmd_data;
          if (i_cmd_op == OP_LOAD) begin
            cnt_d   = CNT_ONE;
            state_d = ST_EXEC;
          end else if (!op_is_legal(i_cmd_op) || (i_cmd_count == CNT_ZERO)) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_DONE;
          end else begin
            cnt_d   = i_cmd_count;
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (abort_s) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // Controller FSM state and registered handshake/status outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= CNT_ZERO;
      data_q    <= {WIDTH{1'b0}};
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Register control: step only in a non-aborted EXEC cycle, otherwise reload o_q.
  always_comb begin
    en_load_s = 1'b1;
    mode_s    = MODE_SHL;
    load_s    = q_s;
    if ((state_q == ST_EXEC) && !abort_s) begin
      case (op_q)
        OP_LOAD: begin
          load_s = data_q;
        end
        OP_SHL: begin
          en_load_s = 1'b0;
          mode_s    = MODE_SHL;
          load_s[0] = i_serial_in;
        end
        OP_SHR: begin
          en_load_s       = 1'b0;
          mode_s          = MODE_SHR;
          load_s[WIDTH-1] = i_serial_in;
        end
        OP_ROTL: begin
          en_load_s = 1'b0;
          mode_s    = MODE_ROTL;
        end
        OP_ROTR: begin
          en_load_s = 1'b0;
          mode_s    = MODE_ROTR;
        end
        default: begin
          en_load_s = 1'b1;
        end
      endcase
    end else begin
      en_load_s = 1'b1;
    end
  end

  // Outgoing serial bit follows the direction of the last captured op.
  always_comb begin
    if (op_exits_msb(op_q)) begin
      serial_out_s = q_s[WIDTH-1];
    end else begin
      serial_out_s = q_s[0];
    end
  end

  universal_shift_register #(
    .WIDTH(WIDTH)
  ) u_usr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en_load(en_load_s),
    .i_mode   (mode_s),
    .i_load   (load_s),
    .o_q      (q_s)
  );

  assign o_q          = q_s;
  assign o_serial_out = serial_out_s;
  assign o_cmd_ready  = ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Self-checking bench for shift_op_sequencer (WIDTH=4) against an arithmetic
// reference model; abort scenario runs when SHIFT_SEQ_ABORT_EN is defined.
module tb_shift_op_sequencer;

  logic       i_clk;
  logic       i_rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_op;
  logic [2:0] i_cmd_count;
  logic [3:0] i_cmd_data;
  logic       i_serial_in;
  logic [3:0] o_q;
  logic       o_serial_out;
  logic       o_busy;
  logic       o_done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       i_abort;
  logic       o_aborted;
`endif

  int total;
  int bad;
  logic [3:0] mq;

  shift_op_sequencer #(.WIDTH(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_count (i_cmd_count),
    .i_cmd_data  (i_cmd_data),
    .i_serial_in (i_serial_in),
`ifdef SHIFT_SEQ_ABORT_EN
    .i_abort     (i_abort),
    .o_aborted   (o_aborted),
`endif
    .o_q         (o_q),
    .o_serial_out(o_serial_out),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One register step computed with plain integer arithmetic.
  function automatic logic [3:0] ref_step(input logic [2:0] op, input logic [3:0] q,
                                          input logic [3:0] d, input logic s);
    int v;
    int qi;
    qi = int'(q);
    case (op)
      3'd0:    v = int'(d);
      3'd1:    v = (qi * 2 + int'(s)) % 16;
      3'd2:    v = qi / 2 + int'(s) * 8;
      3'd3:    v = (qi * 2 + qi / 8) % 16;
      3'd4:    v = qi / 2 + (qi % 2) * 8;
      default: v = qi;
    endcase
    return v[3:0];
  endfunction

  function automatic int ref_steps(input logic [2:0] op, input logic [2:0] cnt);
    if (op == 3'd0) return 1;
    if (op > 3'd4) return 0;
    return int'(cnt);
  endfunction

  // Issue one command at a negedge with the DUT idle; follows it through done.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
    int n;
    int lat;
    logic [3:0] cur;
    logic sins[$];
    logic exp_so;
    n   = ref_steps(op, cnt);
    cur = mq;
    lat = -1;
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_cmd: got %b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_count = cnt;
    i_cmd_data  = data;
    i_serial_in = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      i_cmd_op    = 3'($urandom_range(0, 7));
      i_cmd_count = 3'($urandom_range(0, 4));
      i_cmd_data  = 4'($urandom_range(0, 15));
      if (i >= 1 && i <= n) cur = ref_step(op, cur, data, sins[i-1]);
      if (o_done === 1'b1) begin
        lat = i;
        break;
      end
      total++;
      if (o_q !== cur || o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL step op=%0d i=%0d: q=%b ready=%b busy=%b want q=%b ready=0 busy=1",
                 op, i, o_q, o_cmd_ready, o_busy, cur);
      end
      i_serial_in = 1'($urandom_range(0, 1));
      sins.push_back(i_serial_in);
    end
    total++;
    if (lat != n) begin
      bad++;
      $display("FAIL done_latency op=%0d cnt=%0d: got %0d want %0d", op, cnt, lat, n);
    end
    total++;
    if (o_q !== cur || o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_state op=%0d: q=%b busy=%b ready=%b want q=%b busy=1 ready=0",
               op, o_q, o_busy, o_cmd_ready, cur);
    end
`ifdef SHIFT_SEQ_ABORT_EN
    total++;
    if (o_aborted !== 1'b0) begin
      bad++;
      $display("FAIL aborted_normal: got %b want 0", o_aborted);
    end
`endif
    mq = cur;
    @(negedge i_clk);
    exp_so = (op == 3'd1 || op == 3'd3) ? mq[3] : mq[0];
    total++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_q !== mq ||
        o_serial_out !== exp_so) begin
      bad++;
      $display("FAIL after_done op=%0d: ready=%b busy=%b done=%b q=%b so=%b want 1 0 0 %b %b",
               op, o_cmd_ready, o_busy, o_done, o_q, o_serial_out, mq, exp_so);
    end
  endtask

  task automatic test_reset();
    i_rst       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 3'd0;
    i_cmd_count = 3'd0;
    i_cmd_data  = 4'd0;
    i_serial_in = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    i_abort     = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    total++;
    if (o_q !== 4'b0000 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: q=%b ready=%b busy=%b done=%b want 0000 1 0 0",
               o_q, o_cmd_ready, o_busy, o_done);
    end
    i_rst = 1'b1;
    mq    = 4'b0000;
    @(negedge i_clk);
  endtask

  task automatic test_load();
    do_cmd(3'd0, 3'd0, 4'b1011);
    total++;
    if (o_q !== 4'b1011) begin
      bad++;
      $display("FAIL load_value: got %b want 1011", o_q);
    end
  endtask

  task automatic test_shift();
    do_cmd(3'd0, 3'd0, 4'b1011);
    do_cmd(3'd1, 3'd2, 4'b0000);
    do_cmd(3'd2, 3'd1, 4'b0000);
    do_cmd(3'd1, 3'd4, 4'b0000);
    do_cmd(3'd2, 3'd4, 4'b0000);
  endtask

  task automatic test_rotate();
    do_cmd(3'd0, 3'd0, 4'b1011);
    do_cmd(3'd4, 3'd1, 4'b0000);
    total++;
    if (o_q !== 4'b1101) begin
      bad++;
      $display("FAIL rotr1: got %b want 1101", o_q);
    end
    do_cmd(3'd3, 3'd4, 4'b0000);
    total++;
    if (o_q !== 4'b1101) begin
      bad++;
      $display("FAIL rotl4: got %b want 1101", o_q);
    end
    do_cmd(3'd4, 3'd0, 4'b0000);
    do_cmd(3'd6, 3'd3, 4'b0101);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      i_cmd_valid = 1'b0;
      i_cmd_op    = 3'($urandom_range(0, 7));
      i_cmd_count = 3'($urandom_range(0, 4));
      i_cmd_data  = 4'($urandom_range(0, 15));
      i_serial_in = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      total++;
      if (o_q !== mq || o_done !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold: q=%b done=%b busy=%b want %b 0 0", o_q, o_done, o_busy, mq);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      do_cmd(op, 3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_abort();
    do_cmd(3'd0, 3'd0, 4'b1011);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 3'd3;
    i_cmd_count = 3'd4;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_q !== 4'b0111) begin
      bad++;
      $display("FAIL rotl_step1: got %b want 0111", o_q);
    end
    i_rst = 1'b0;
    #1;
    total++;
    if (o_q !== 4'b0000 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_cmd: q=%b done=%b want 0000 0", o_q, o_done);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      total++;
      if (o_done !== 1'b0 || o_q !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold: done=%b q=%b want 0 0000", o_done, o_q);
      end
    end
    i_rst = 1'b1;
    mq    = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++;
      if (o_cmd_ready !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL after_reset: ready=%b done=%b busy=%b want 1 0 0",
                 o_cmd_ready, o_done, o_busy);
      end
    end
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    do_cmd(3'd0, 3'd0, 4'b1011);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 3'd1;
    i_cmd_count = 3'd4;
    i_serial_in = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    total++;
    if (o_q !== 4'b1100 || o_done !== 1'b1 || o_aborted !== 1'b1) begin
      bad++;
      $display("FAIL abort: q=%b done=%b aborted=%b want 1100 1 1", o_q, o_done, o_aborted);
    end
    @(negedge i_clk);
    total++;
    if (o_cmd_ready !== 1'b1 || o_aborted !== 1'b0 || o_q !== 4'b1100) begin
      bad++;
      $display("FAIL after_abort: ready=%b aborted=%b q=%b want 1 0 1100",
               o_cmd_ready, o_aborted, o_q);
    end
    mq = 4'b1100;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_idle();
    test_back_to_back();
    test_reset_abort();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
